// File: rtl/ncpu32k_ie_lsu.sv
// Pipelined load/store unit: issues bus commands, tracks up to DEPTH ops in flight
// and retires them to WB in issue order with alignment, extension and exceptions.
module ncpu32k_ie_lsu #(
    parameter int DEPTH                 = 2,
    parameter bit ENABLE_PIPEBUF_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ieu_lsu_in_valid,
    output logic        ieu_lsu_in_ready,
    input  logic [31:0] ieu_operand_1,
    input  logic [31:0] ieu_operand_2,
    input  logic [31:0] ieu_operand_3,
    input  logic        ieu_lsu_load,
    input  logic        ieu_lsu_store,
    input  logic [2:0]  ieu_lsu_size,
    input  logic        ieu_lsu_signed,
    output logic        dbus_cmd_valid,
    input  logic        dbus_cmd_ready,
    output logic [31:0] dbus_cmd_addr,
    output logic        dbus_cmd_we,
    output logic [3:0]  dbus_cmd_wmsk,
    output logic [31:0] dbus_cmd_dat,
    input  logic        dbus_rsp_valid,
    output logic        dbus_rsp_ready,
    input  logic [31:0] dbus_rsp_dat,
    input  logic        dbus_rsp_err,
    output logic        wb_lsu_in_valid,
    input  logic        wb_lsu_in_ready,
    output logic [31:0] lsu_wb_dat,
    output logic        lsu_wb_we,
    output logic [1:0]  lsu_wb_exc,
    output logic        lsu_busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic       load;
        logic       sgn;
        logic [2:0] size;
        logic [1:0] a;
        logic       exc;
    } ent_t;

    ent_t          fifo_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    logic        mem, mis, sz_b, sz_h, sz_w, full, space, push, pop, ok_ld;
    logic [1:0]  a;
    logic [31:0] w, ext;
    ent_t        head;

    assign mem  = ieu_lsu_load | ieu_lsu_store;
    assign sz_b = (ieu_lsu_size == 3'd1);
    assign sz_h = (ieu_lsu_size == 3'd2);
    assign sz_w = (ieu_lsu_size == 3'd4);
    assign dbus_cmd_addr = ieu_operand_1 + ieu_operand_2;
    assign a    = dbus_cmd_addr[1:0];
    assign mis  = mem & (~(sz_b | sz_h | sz_w) | (sz_h & a[0]) | (sz_w & (a != 2'b00)));

    assign full     = (cnt_q == CW'(DEPTH));
    assign lsu_busy = (cnt_q != '0);
    assign head     = fifo_q[rd_q];

    assign wb_lsu_in_valid = lsu_busy & (head.exc | dbus_rsp_valid);
    assign dbus_rsp_ready  = lsu_busy & ~head.exc & wb_lsu_in_ready;
    assign pop             = wb_lsu_in_valid & wb_lsu_in_ready;

    // A retiring head frees its slot for the incoming op in the same cycle.
    assign space            = ~full | (ENABLE_PIPEBUF_BYPASS & pop);
    assign ieu_lsu_in_ready = ~mem | (space & (mis | dbus_cmd_ready));
    assign dbus_cmd_valid   = ieu_lsu_in_valid & mem & ~mis & space;
    assign dbus_cmd_we      = ieu_lsu_store;
    assign push             = ieu_lsu_in_valid & ieu_lsu_in_ready & mem;

    always_comb begin
        dbus_cmd_wmsk = 4'h0;
        dbus_cmd_dat  = ieu_operand_3;
        if (sz_b) begin
            dbus_cmd_wmsk = 4'b0001 << a;
            dbus_cmd_dat  = {4{ieu_operand_3[7:0]}};
        end else if (sz_h) begin
            dbus_cmd_wmsk = 4'b0011 << a;
            dbus_cmd_dat  = {2{ieu_operand_3[15:0]}};
        end else if (sz_w) begin
            dbus_cmd_wmsk = 4'hF;
        end
        if (!ieu_lsu_store)
            dbus_cmd_wmsk = 4'h0;
    end

    always_comb begin
        w   = dbus_rsp_dat >> {head.a, 3'b000};
        ext = w;
        case (head.size)
            3'd1:    ext = {{24{head.sgn & w[7]}}, w[7:0]};
            3'd2:    ext = {{16{head.sgn & w[15]}}, w[15:0]};
            default: ext = w;
        endcase
    end

    assign ok_ld      = wb_lsu_in_valid & head.load & ~head.exc & ~dbus_rsp_err;
    assign lsu_wb_we  = ok_ld;
    assign lsu_wb_dat = ok_ld ? ext : 32'h0;
    assign lsu_wb_exc = ~wb_lsu_in_valid ? 2'b00 :
                        head.exc         ? 2'b01 :
                        dbus_rsp_err     ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_q] <= '{load: ieu_lsu_load, sgn: ieu_lsu_signed,
                              size: ieu_lsu_size, a: a, exc: mis};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push)
                wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
            if (pop)
                rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_ncpu32k_ie_lsu.sv
// Directed bench for ncpu32k_ie_lsu; a second instance without bypass covers the
// full-FIFO acceptance timing difference.
module tb_ncpu32k_ie_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, load = 1'b0, store = 1'b0, sgn = 1'b0;
    logic [2:0]  size = 3'd0;
    logic [31:0] op1 = '0, op2 = '0, op3 = '0;
    logic        cmd_ready = 1'b0, rsp_valid = 1'b0, rsp_err = 1'b0, wb_ready = 1'b0;
    logic [31:0] rsp_dat = '0;

    logic        in_ready, cmd_valid, cmd_we, rsp_ready, wb_valid, wb_we, busy;
    logic [31:0] cmd_addr, cmd_dat, wb_dat;
    logic [3:0]  cmd_wmsk;
    logic [1:0]  wb_exc;

    logic        n_in_ready, n_cmd_valid, n_cmd_we, n_rsp_ready, n_wb_valid, n_wb_we, n_busy;
    logic [31:0] n_cmd_addr, n_cmd_dat, n_wb_dat;
    logic [3:0]  n_cmd_wmsk;
    logic [1:0]  n_wb_exc;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    ncpu32k_ie_lsu #(.DEPTH(2), .ENABLE_PIPEBUF_BYPASS(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ieu_lsu_in_valid(in_valid), .ieu_lsu_in_ready(in_ready),
        .ieu_operand_1(op1), .ieu_operand_2(op2), .ieu_operand_3(op3),
        .ieu_lsu_load(load), .ieu_lsu_store(store), .ieu_lsu_size(size), .ieu_lsu_signed(sgn),
        .dbus_cmd_valid(cmd_valid), .dbus_cmd_ready(cmd_ready), .dbus_cmd_addr(cmd_addr),
        .dbus_cmd_we(cmd_we), .dbus_cmd_wmsk(cmd_wmsk), .dbus_cmd_dat(cmd_dat),
        .dbus_rsp_valid(rsp_valid), .dbus_rsp_ready(rsp_ready), .dbus_rsp_dat(rsp_dat),
        .dbus_rsp_err(rsp_err),
        .wb_lsu_in_valid(wb_valid), .wb_lsu_in_ready(wb_ready),
        .lsu_wb_dat(wb_dat), .lsu_wb_we(wb_we), .lsu_wb_exc(wb_exc), .lsu_busy(busy)
    );

    ncpu32k_ie_lsu #(.DEPTH(2), .ENABLE_PIPEBUF_BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n),
        .ieu_lsu_in_valid(in_valid), .ieu_lsu_in_ready(n_in_ready),
        .ieu_operand_1(op1), .ieu_operand_2(op2), .ieu_operand_3(op3),
        .ieu_lsu_load(load), .ieu_lsu_store(store), .ieu_lsu_size(size), .ieu_lsu_signed(sgn),
        .dbus_cmd_valid(n_cmd_valid), .dbus_cmd_ready(cmd_ready), .dbus_cmd_addr(n_cmd_addr),
        .dbus_cmd_we(n_cmd_we), .dbus_cmd_wmsk(n_cmd_wmsk), .dbus_cmd_dat(n_cmd_dat),
        .dbus_rsp_valid(rsp_valid), .dbus_rsp_ready(n_rsp_ready), .dbus_rsp_dat(rsp_dat),
        .dbus_rsp_err(rsp_err),
        .wb_lsu_in_valid(n_wb_valid), .wb_lsu_in_ready(wb_ready),
        .lsu_wb_dat(n_wb_dat), .lsu_wb_we(n_wb_we), .lsu_wb_exc(n_wb_exc), .lsu_busy(n_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic ld, input logic st, input logic [2:0] sz, input logic sg,
                          input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
        in_valid = 1'b1; load = ld; store = st; size = sz; sgn = sg;
        op1 = a1; op2 = a2; op3 = a3;
    endtask

    task automatic clr_op();
        in_valid = 1'b0; load = 1'b0; store = 1'b0; size = 3'd0; sgn = 1'b0;
    endtask

    task automatic rsp(input logic v, input logic [31:0] d, input logic e);
        rsp_valid = v; rsp_dat = d; rsp_err = e;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_rspr", rsp_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmd_ready = 1'b1; wb_ready = 1'b1;

        // 1: word load
        @(negedge clk); set_op(1, 0, 3'd4, 0, 32'h100, 32'h4, 32'h0); #1;
        chk("t1_cmdv", cmd_valid, 1);
        chk("t1_addr", cmd_addr, 32'h104);
        chk("t1_we", cmd_we, 0);
        chk("t1_wmsk", cmd_wmsk, 0);
        chk("t1_wbv_lat", wb_valid, 0);
        @(negedge clk); clr_op(); rsp(1, 32'hDEADBEEF, 0); #1;
        chk("t1_wbv", wb_valid, 1);
        chk("t1_dat", wb_dat, 32'hDEADBEEF);
        chk("t1_wbwe", wb_we, 1);
        chk("t1_exc", wb_exc, 0);
        chk("t1_rspr", rsp_ready, 1);
        @(negedge clk); rsp(0, 0, 0); #1;
        chk("t1_idle", busy, 0);

        // 2: byte load at 0x103, signed then unsigned
        @(negedge clk); set_op(1, 0, 3'd1, 1, 32'h100, 32'h3, 32'h0); #1;
        chk("t2_addr", cmd_addr, 32'h103);
        @(negedge clk); clr_op(); rsp(1, 32'h80112233, 0); #1;
        chk("t2_sdat", wb_dat, 32'hFFFFFF80);
        @(negedge clk); rsp(0, 0, 0); set_op(1, 0, 3'd1, 0, 32'h100, 32'h3, 32'h0);
        @(negedge clk); clr_op(); rsp(1, 32'h80112233, 0); #1;
        chk("t2_udat", wb_dat, 32'h00000080);
        @(negedge clk); rsp(0, 0, 0);

        // 3: half store at 0x102
        set_op(0, 1, 3'd2, 0, 32'h100, 32'h2, 32'h1234ABCD); #1;
        chk("t3_cmdv", cmd_valid, 1);
        chk("t3_we", cmd_we, 1);
        chk("t3_wmsk", cmd_wmsk, 4'b1100);
        chk("t3_dat", cmd_dat, 32'hABCDABCD);
        @(negedge clk); clr_op(); rsp(1, 32'h0, 0); #1;
        chk("t3_wbv", wb_valid, 1);
        chk("t3_wbwe", wb_we, 0);
        chk("t3_wbdat", wb_dat, 0);
        @(negedge clk); rsp(0, 0, 0);

        // 4: word load outstanding, then misaligned half load
        set_op(1, 0, 3'd4, 0, 32'h200, 32'h0, 32'h0);
        @(negedge clk); set_op(1, 0, 3'd2, 0, 32'h200, 32'h1, 32'h0); #1;
        chk("t4_cmdv", cmd_valid, 0);
        chk("t4_inr", in_ready, 1);
        @(negedge clk); clr_op(); #1;
        chk("t4_wait", wb_valid, 0);
        @(negedge clk); rsp(1, 32'h11223344, 0); #1;
        chk("t4_dat1", wb_dat, 32'h11223344);
        chk("t4_exc1", wb_exc, 0);
        @(negedge clk); rsp(0, 0, 0); #1;
        chk("t4_wbv2", wb_valid, 1);
        chk("t4_exc2", wb_exc, 2'b01);
        chk("t4_we2", wb_we, 0);
        chk("t4_rspr2", rsp_ready, 0);
        @(negedge clk); #1;
        chk("t4_idle", busy, 0);

        // illegal size goes straight to exception
        set_op(1, 0, 3'd3, 0, 32'h400, 32'h0, 32'h0); #1;
        chk("ill_cmdv", cmd_valid, 0);
        @(negedge clk); clr_op(); #1;
        chk("ill_exc", wb_exc, 2'b01);
        @(negedge clk);

        // 5: full FIFO, bypass vs no bypass
        set_op(1, 0, 3'd4, 0, 32'h300, 32'h0, 32'h0);
        @(negedge clk); set_op(1, 0, 3'd4, 0, 32'h304, 32'h0, 32'h0);
        @(negedge clk); set_op(1, 0, 3'd4, 0, 32'h308, 32'h0, 32'h0); #1;
        chk("t5_full_b", in_ready, 0);
        chk("t5_full_nb", n_in_ready, 0);
        chk("t5_cmdv", cmd_valid, 0);
        @(negedge clk); rsp(1, 32'hA5A5A5A5, 0); #1;
        chk("t5_ret_dat", wb_dat, 32'hA5A5A5A5);
        chk("t5_byp_b", in_ready, 1);
        chk("t5_byp_cmd", cmd_valid, 1);
        chk("t5_byp_nb", n_in_ready, 0);
        @(negedge clk); rsp(0, 0, 0); #1;
        chk("t5_late_b", in_ready, 0);
        chk("t5_late_nb", n_in_ready, 1);

        // 6: reset with two loads outstanding
        @(negedge clk); clr_op(); rsp(1, 32'h12345678, 0); wb_ready = 1'b0; #1;
        chk("t6_busy_pre", busy, 1);
        chk("t6_busy_pre_nb", n_busy, 1);
        wb_ready = 1'b1; rst_n = 1'b0; #1;
        chk("t6_busy", busy, 0);
        chk("t6_wbv", wb_valid, 0);
        chk("t6_rspr", rsp_ready, 0);
        chk("t6_busy_nb", n_busy, 0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("t6_stray_r", rsp_ready, 0);
        chk("t6_stray_v", wb_valid, 0);

        // bus error on a fresh load after reset
        @(negedge clk); rsp(0, 0, 0); set_op(1, 0, 3'd4, 0, 32'h10, 32'h0, 32'h0);
        @(negedge clk); clr_op(); rsp(1, 32'hCAFEF00D, 1); #1;
        chk("berr_exc", wb_exc, 2'b10);
        chk("berr_we", wb_we, 0);
        chk("berr_dat", wb_dat, 0);
        @(negedge clk); rsp(0, 0, 0); #1;
        chk("berr_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
